// File: rtl/seq_wide_add_sub.sv
// seq_wide_add_sub: multi-cycle wide adder-subtractor.
//
// Streams two W-bit operands through one M-bit carry-lookahead slice (claAddSubGen), LSB slice
// first, one slice per clock. The slice carry/borrow-out is registered and fed back as the next
// slice's carry/borrow-in. The full result and flags are held until the consumer takes them.
//
// Optional feature macro: SEQ_WIDE_ADD_SUB_BACK2BACK_EN
//   defined   : a new request may be accepted in the same cycle the result is handed off.
//   undefined : a new request is accepted only from IDLE.
//
// claAddSubGen ports:
//   x, y   in  M  slice operands
//   sub    in  1  0 = x+y+cin, 1 = x-y-cin
//   cin    in  1  carry-in (add) / borrow-in (sub)
//   out    out M  slice result
//   cout   out 1  carry-out (add) / borrow-out (sub)
//   v      out 1  signed overflow of the slice operation
//   g, p   out 1  group generate / propagate across the whole slice
//
// seq_wide_add_sub ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand request handshake
//   sub, cin, a, b      operation select, carry/borrow-in and operands, captured on accept
//   out_valid, out_ready result handshake
//   result, cout, v, z  W-bit result, MS-slice carry/borrow-out, signed overflow, result == 0

module claAddSubGen #(
    parameter int unsigned M = 16
) (
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    input  logic         sub,
    input  logic         cin,
    output logic [M-1:0] out,
    output logic         cout,
    output logic         v,
    output logic         g,
    output logic         p
);
    localparam int unsigned L = $clog2(M);

    logic [M-1:0]        y_eff;
    logic                c0;
    logic [L:0][M-1:0]   gg;
    logic [L:0][M-1:0]   pp;
    logic [M:0]          c;

    // Subtraction as x + ~y + ~borrow_in; the carry out is inverted back into a borrow.
    assign y_eff = y ^ {M{sub}};
    assign c0    = cin ^ sub;

    assign gg[0] = x & y_eff;
    assign pp[0] = x ^ y_eff;

    // Kogge-Stone prefix: after level L, gg[L][i]/pp[L][i] span bits i..0.
    for (genvar lv = 0; lv < L; lv++) begin : g_level
        for (genvar i = 0; i < M; i++) begin : g_bit
            if (i >= (1 << lv)) begin : g_comb
                assign gg[lv+1][i] = gg[lv][i] | (pp[lv][i] & gg[lv][i-(1<<lv)]);
                assign pp[lv+1][i] = pp[lv][i] & pp[lv][i-(1<<lv)];
            end else begin : g_pass
                assign gg[lv+1][i] = gg[lv][i];
                assign pp[lv+1][i] = pp[lv][i];
            end
        end
    end

    assign c[0] = c0;
    for (genvar i = 0; i < M; i++) begin : g_carry
        assign c[i+1] = gg[L][i] | (pp[L][i] & c0);
    end

    assign out  = pp[0] ^ c[M-1:0];
    assign cout = c[M] ^ sub;
    assign v    = c[M] ^ c[M-1];
    assign g    = gg[L][M-1];
    assign p    = pp[L][M-1];
endmodule

module seq_wide_add_sub #(
    parameter int unsigned W = 64,
    parameter int unsigned M = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         v,
    output logic         z
);
    localparam int unsigned N  = W / M;
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sub_q, sub_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] k_q, k_d;
    logic          z_acc_q, z_acc_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          v_q, v_d;
    logic          z_q, z_d;

    logic [M-1:0]  x_slice, y_slice, slice_sum;
    logic          slice_cout, slice_v, slice_zero;
    logic          capture;

    assign x_slice    = a_q[k_q*M +: M];
    assign y_slice    = b_q[k_q*M +: M];
    assign slice_zero = (slice_sum == '0);

    claAddSubGen #(
        .M(M)
    ) u_slice_adder (
        .x    (x_slice),
        .y    (y_slice),
        .sub  (sub_q),
        .cin  (carry_q),
        .out  (slice_sum),
        .cout (slice_cout),
        .v    (slice_v),
        .g    (),
        .p    ()
    );

`ifdef SEQ_WIDE_ADD_SUB_BACK2BACK_EN
    assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
`else
    assign in_ready = (state_q == StIdle);
`endif

    assign out_valid = (state_q == StDone);
    assign capture   = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        k_d      = k_q;
        z_acc_d  = z_acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        v_d      = v_q;
        z_d      = z_q;

        unique case (state_q)
            StIdle: ;
            StRun: begin
                result_d[k_q*M +: M] = slice_sum;
                carry_d              = slice_cout;
                z_acc_d              = z_acc_q & slice_zero;
                k_d                  = k_q + CW'(1);
                if (k_q == K_LAST) begin
                    cout_d  = slice_cout;
                    v_d     = slice_v;
                    z_d     = z_acc_q & slice_zero;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A capture in DONE (back-to-back build) overrides the return to IDLE.
        if (capture) begin
            a_d     = a;
            b_d     = b;
            sub_d   = sub;
            carry_d = cin;
            k_d     = '0;
            z_acc_d = 1'b1;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            z_acc_q  <= 1'b1;
            result_q <= '0;
            cout_q   <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
            z_acc_q  <= z_acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            v_q      <= v_d;
            z_q      <= z_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign v      = v_q;
    assign z      = z_q;
endmodule

// File: tb/tb_seq_wide_add_sub.sv
// Directed bench for seq_wide_add_sub at W=64, M=16 (four slices).
module tb_seq_wide_add_sub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        cout;
    logic        v;
    logic        z;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [63:0] held;

    seq_wide_add_sub #(
        .W(64),
        .M(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .v         (v),
        .z         (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at the negedge and release it after the accepting edge.
    task automatic start_op(input logic s, input logic ci, input logic [63:0] av,
                            input logic [63:0] bv);
        @(negedge clk);
        sub = s; cin = ci; a = av; b = bv; in_valid = 1'b1;
        check("in_ready_at_request", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_take", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_check(input string tag, input logic s, input logic ci,
                             input logic [63:0] av, input logic [63:0] bv,
                             input logic [63:0] er, input logic ec, input logic ev,
                             input logic ez);
        start_op(s, ci, av, bv);
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_result"}, result, er);
        check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
        check({tag, "_v"}, {63'd0, v}, {63'd0, ev});
        check({tag, "_z"}, {63'd0, z}, {63'd0, ez});
        consume();
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_result", result, 64'd0);
        check("rst_flags", {61'd0, cout, v, z}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1-4: carry chaining, overflow, borrow, zero flag.
        run_check("add_ffff_1", 1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'd1,
                  64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        run_check("add_allones_1", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                  64'd0, 1'b1, 1'b0, 1'b1);
        run_check("add_maxpos_1", 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_check("sub_0_1", 1'b1, 1'b0, 64'd0, 64'd1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_check("sub_minneg_1", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_check("sub_5_5", 1'b1, 1'b0, 64'd5, 64'd5, 64'd0, 1'b0, 1'b0, 1'b1);
        run_check("sub_5_4_bin", 1'b1, 1'b1, 64'd5, 64'd4, 64'd0, 1'b0, 1'b0, 1'b1);

        // 5: hold in DONE with out_ready low while inputs wiggle.
        start_op(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111);
        wait_done(lat);
        check("hold_latency", 64'(lat), 64'd4);
        held = 64'h2345_6789_ABCD_F001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = a + 64'h0101;
            b = ~b;
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", result, held);
            check("hold_flags", {61'd0, cout, v, z}, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        check("hold_no_second_accept", {63'd0, in_ready}, 64'd1);

`ifdef SEQ_WIDE_ADD_SUB_BACK2BACK_EN
        // Result handoff and new capture on the same edge.
        start_op(1'b0, 1'b0, 64'd1, 64'd1);
        wait_done(lat);
        check("b2b_first_result", result, 64'd2);
        @(negedge clk);
        a = 64'd10; b = 64'd20; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_out_valid_drop", {63'd0, out_valid}, 64'd0);
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'd4);
        check("b2b_result", result, 64'd30);
        consume();
`endif

        // 6: reset two slices into RUN, then a clean op.
        start_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after_abort_3_4", 1'b0, 1'b0, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
